bin2bcd_serial: RTL and testbench
=================================

// Module: bin2bcd_serial
// PURPOSE
//   Multi-cycle, parametrised binary-to-BCD converter using shift-add-3 (double dabble).
//   Does one shift per clock, so area stays flat as WIDTH grows.
//   Sits between arithmetic/counter logic and display or UART formatting.
//   Uses a valid/ready handshake on both input and output.
//   Adds over the combinational 8-bit converter: any WIDTH, any DIGITS, back-pressure,
//   an overflow flag and an optional signed mode.
// PARAMETERS
//   WIDTH   8  binary input width, >= 2
//   DIGITS  3  BCD digits produced, >= 1; full range needs 10**DIGITS > 2**WIDTH - 1
//   CNT_W   $clog2(WIDTH+1)  shift-counter width, localparam (not overridable)
// PORTS
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous, active-high reset
//   in_valid   in   1           in_bin is valid
//   in_ready   out  1           converter can accept a new value
//   in_bin     in   WIDTH       binary operand (unsigned, or two's complement with macro)
//   out_valid  out  1           out_bcd/out_ovf/out_neg valid
//   out_ready  in   1           downstream accepts the result
//   out_bcd    out  4*DIGITS    packed BCD; [3:0] = ones, [7:4] = tens, ...
//   out_ovf    out  1           value did not fit in DIGITS digits
//   out_neg    out  1           input was negative (signed mode only, else 0)
// BEHAVIOUR
//   Reset values (rst high at a rising edge, from any state)
//     - state = IDLE, in_ready = 1, out_valid = 0, out_bcd = 0, out_ovf = 0, out_neg = 0, counter = 0.
//     - Reset mid-conversion discards the work in progress; no result is emitted.
//   FSM states: IDLE, SHIFT, DONE
//     - IDLE: in_ready = 1. If in_valid at an edge: load shift reg {BCD = 0, bin = in_bin},
//       set counter = 0, clear the overflow accumulator, go to SHIFT.
//     - SHIFT: in_ready = 0. At each edge, first every BCD digit >= 5 gets +3 (4-bit, no carry
//       between digits); then the whole {BCD, bin} register shifts left by 1.
//       Bit shifted out of the top digit: OR it into the ovf accumulator.
//       Counter increments; after the WIDTH-th shift edge, go to DONE.
//     - DONE: out_valid = 1 and the outputs are stable. If out_ready at an edge, go to IDLE.
//   Timing
//     - Acceptance at edge E0: out_valid is seen high after edge E0+WIDTH.
//     - With out_ready held at 1: in_ready is back after E0+WIDTH+1.
//     - Throughput: one conversion per WIDTH+2 cycles.
//   Rules
//     - in_valid is ignored outside IDLE. in_bin is sampled only at the accept edge.
//     - Outputs hold their value while out_valid=1 && out_ready=0, for any length of time.
//     - out_bcd, out_ovf and out_neg keep the last result after the handshake,
//       until the next DONE is entered.
//     - out_ovf = 1 means out_bcd holds the low DIGITS digits of the true value
//       (this is the wrapped value).
//     - Digits never hold values > 9 when out_ovf = 0.
// CONFIGURATION
//   Macro BIN2BCD_SIGNED_EN
//     - Defined: in_bin is two's complement. At accept, magnitude = in_bin[WIDTH-1] ? -in_bin : in_bin,
//       taken as WIDTH-bit unsigned, so -2**(WIDTH-1) converts correctly.
//       out_neg = in_bin[WIDTH-1], latched at accept and updated when DONE is entered.
//       Latency is unchanged.
//     - Undefined: in_bin is unsigned; out_neg is tied to 0; there is no negation logic.
// TESTING
//   1. WIDTH=8, DIGITS=3, in_bin=255, out_ready=1 -> out_bcd=12'h255, ovf=0;
//      out_valid 8 edges after accept; next accept 10 edges after the previous one.
//   2. in_bin=0, then in_bin=9, back to back -> 12'h000, then 12'h009; in_ready low throughout each conversion.
//   3. in_bin=137, out_ready=0 for 5 cycles after out_valid -> 12'h137 held stable;
//      in_valid pulses are ignored; IDLE is entered one edge after out_ready rises.
//   4. rst asserted at the 4th shift of in_bin=200 -> next cycle in_ready=1, out_valid=0, out_bcd=0;
//      a fresh 42 then gives 12'h042.
//   5. WIDTH=8, DIGITS=2, in_bin=100 -> out_bcd=8'h00, out_ovf=1; in_bin=99 -> 8'h99, out_ovf=0.
//   6. BIN2BCD_SIGNED_EN, WIDTH=8: in_bin=8'h80 -> out_neg=1, out_bcd=12'h128;
//      in_bin=8'hFF -> out_neg=1, 12'h001; 8'h7F -> out_neg=0, 12'h127.

Source files
------------

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-add-3, one shift per clock) with valid/ready on both sides.
// Define BIN2BCD_SIGNED_EN to treat in_bin as two's complement and report the sign on out_neg.
module bin2bcd_serial #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf,
  output logic                  out_neg
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BW    = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [BW-1:0]     sr_bcd, adj_bcd, shf_bcd;
  logic [WIDTH-1:0]  sr_bin, shf_bin, load_bin;
  logic              ovf_acc, shf_out;
  logic              accept, last_shift;

  // Per-digit correction; no carry between digits.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  assign accept     = (state == IDLE) && in_valid;
  assign last_shift = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    adj_bcd = '0;
    for (int i = 0; i < DIGITS; i++)
      adj_bcd[4*i +: 4] = add3(sr_bcd[4*i +: 4]);
  end

  // The bit leaving the top digit is worth 10**DIGITS and feeds the overflow flag.
  assign {shf_out, shf_bcd, shf_bin} = {adj_bcd, sr_bin, 1'b0};

`ifdef BIN2BCD_SIGNED_EN
  // Taken as WIDTH-bit unsigned so the most negative value maps to 2**(WIDTH-1).
  assign load_bin = in_bin[WIDTH-1] ? (WIDTH'(0) - in_bin) : in_bin;
`else
  assign load_bin = in_bin;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sr_bcd  <= '0;
      sr_bin  <= load_bin;
      ovf_acc <= 1'b0;
    end else if (state == SHIFT) begin
      sr_bcd  <= shf_bcd;
      sr_bin  <= shf_bin;
      ovf_acc <= ovf_acc | shf_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      out_bcd <= '0;
      out_ovf <= 1'b0;
    end else begin
      if (accept)              cnt <= '0;
      else if (state == SHIFT) cnt <= cnt + CNT_W'(1);
      // Result registers change only on entry to DONE and hold afterwards.
      if (last_shift) begin
        out_bcd <= shf_bcd;
        out_ovf <= ovf_acc | shf_out;
      end
    end
  end

`ifdef BIN2BCD_SIGNED_EN
  logic neg_q;

  always_ff @(posedge clk) begin
    if (accept) neg_q <= in_bin[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst)             out_neg <= 1'b0;
    else if (last_shift) out_neg <= neg_q;
  end
`else
  assign out_neg = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Bench for bin2bcd_serial: a 3-digit and a 2-digit instance driven in lockstep,
// checked against a decimal-arithmetic reference model.
module tb_bin2bcd_serial;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_bin;
  logic        out_ready;
  logic        in_ready, out_valid, out_ovf, out_neg;
  logic [11:0] out_bcd;
  logic        in_ready2, out_valid2, out_ovf2, out_neg2;
  logic [7:0]  out_bcd2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  bit last_hold0 = 0;

  bin2bcd_serial #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .out_ovf(out_ovf), .out_neg(out_neg)
  );

  bin2bcd_serial #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_bin(in_bin),
    .out_valid(out_valid2), .out_ready(out_ready), .out_bcd(out_bcd2),
    .out_ovf(out_ovf2), .out_neg(out_neg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Low 'digits' decimal digits of v, packed BCD.
  function automatic logic [11:0] ref_bcd(input int unsigned v, input int digits);
    logic [11:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic convert(input logic [7:0] v, input int hold, input bit b2b);
    int unsigned mag;
    logic        nexp;
    logic [11:0] exp3, exp2;
    int          n;
    mag  = v;
    nexp = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    if (v[7]) begin
      mag  = 256 - int'(v);
      nexp = 1'b1;
    end
`endif
    exp3 = ref_bcd(mag, 3);
    exp2 = ref_bcd(mag, 2);
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid  = 1'b1;
    in_bin    = v;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    if (b2b) chk("throughput", cyc - last_acc, 10);
    last_acc = cyc;
    in_valid = 1'b0;
    in_bin   = 8'($urandom);
    chk("busy_in_ready", in_ready, 0);
    for (int k = 1; k < 8; k++) begin
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("early_valid", {out_valid, out_valid2, in_ready}, 3'b000);
    end
    @(posedge clk); #1;
    chk("done_valid", {out_valid, out_valid2}, 2'b11);
    chk("bcd3", out_bcd, exp3);
    chk("ovf3", out_ovf, (mag >= 1000));
    chk("neg3", out_neg, nexp);
    chk("bcd2", out_bcd2, exp2);
    chk("ovf2", out_ovf2, (mag >= 100));
    chk("neg2", out_neg2, nexp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      in_bin   = 8'($urandom);
      @(posedge clk); #1;
      chk("hold_state", {out_valid, in_ready}, 2'b10);
      chk("hold_bcd", {out_bcd, out_bcd2}, {exp3, exp2[7:0]});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_idle", {out_valid, in_ready}, 2'b01);
    chk("kept_bcd", out_bcd, exp3);
    last_hold0 = (hold == 0);
  endtask

  initial begin
    logic [7:0] rv;
    rst = 1'b1; in_valid = 1'b0; in_bin = 8'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ctrl", {in_ready, out_valid}, 2'b10);
    chk("rst_data", {out_bcd, out_ovf, out_neg}, 14'd0);

    convert(8'd255, 0, 0);
    convert(8'd0,   0, 1);
    convert(8'd9,   0, 1);
    convert(8'd137, 5, 0);

    // Reset lands on the 4th shift edge of a conversion.
    in_valid = 1'b1; in_bin = 8'd200; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_ctrl", {in_ready, out_valid}, 2'b10);
    chk("midrst_data", {out_bcd, out_ovf}, 13'd0);
    begin
      bit seen = 0;
      repeat (10) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1;
      end
      chk("midrst_no_result", seen, 0);
    end
    convert(8'd42,  0, 0);
    convert(8'd100, 0, 1);
    convert(8'd99,  0, 1);
    convert(8'h80,  0, 1);
    convert(8'hFF,  0, 1);
    convert(8'h7F,  2, 1);
    convert(8'd1,   0, 0);

    for (int i = 0; i < 20; i++) begin
      rv = 8'($urandom);
      convert(rv, $urandom_range(0, 3), last_hold0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
